// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the ALU issue stage:
//   - RV32I opcode constants for OP and OP-IMM
//   - funct3 / funct7 constants used by the decoder
//   - alu_sel_t: 10-bit one-hot ALU select, bit indices in port order
//     (add, sub, sll, slt, sltu, xor, srl, sra, or, and)
//   - issue_entry_t: the payload held by the pipeline register
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int ALU_N = 10;

  // Bit positions inside alu_sel_t, matching the order of the enable ports.
  localparam int SEL_ADD  = 0;
  localparam int SEL_SUB  = 1;
  localparam int SEL_SLL  = 2;
  localparam int SEL_SLT  = 3;
  localparam int SEL_SLTU = 4;
  localparam int SEL_XOR  = 5;
  localparam int SEL_SRL  = 6;
  localparam int SEL_SRA  = 7;
  localparam int SEL_OR   = 8;
  localparam int SEL_AND  = 9;

  typedef logic [ALU_N-1:0] alu_sel_t;

  typedef struct packed {
    alu_sel_t    sel;
    logic        illegal;
    logic        rd_we;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
  } issue_entry_t;

  // One-hot select with a single bit set at position idx.
  function automatic alu_sel_t sel_bit(input int unsigned idx);
    return alu_sel_t'(1) << idx;
  endfunction

  // Default operation for each funct3 when funct7 is the base encoding.
  function automatic alu_sel_t base_sel(input logic [2:0] funct3);
    alu_sel_t s;
    case (funct3)
      F3_ADD:  s = sel_bit(SEL_ADD);
      F3_SLL:  s = sel_bit(SEL_SLL);
      F3_SLT:  s = sel_bit(SEL_SLT);
      F3_SLTU: s = sel_bit(SEL_SLTU);
      F3_XOR:  s = sel_bit(SEL_XOR);
      F3_SRL:  s = sel_bit(SEL_SRL);
      F3_OR:   s = sel_bit(SEL_OR);
      default: s = sel_bit(SEL_AND);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
//
// Purely combinational decode of an RV32I OP / OP-IMM instruction word into
// the one-hot ALU select.
//
// Ports:
//   instr     in  32  instruction word
//   sel       out 10  one-hot ALU select (all zero when illegal)
//   illegal   out  1  encoding is not a supported OP / OP-IMM operation
//   imm_sel   out  1  operand 2 comes from the I-type immediate
//   shamt_sel out  1  operand 2 is the zero-extended 5-bit shift amount
// -----------------------------------------------------------------------------
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_sel_t    sel,
  output logic        illegal,
  output logic        imm_sel,
  output logic        shamt_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices and rd are not needed for the operation decode.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    sel       = '0;
    legal     = 1'b0;
    imm_sel   = 1'b0;
    shamt_sel = 1'b0;

    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_BASE) begin
              sel   = sel_bit(SEL_ADD);
              legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              sel   = sel_bit(SEL_SUB);
              legal = 1'b1;
            end
          end
          F3_SRL: begin
            if (funct7 == F7_BASE) begin
              sel   = sel_bit(SEL_SRL);
              legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              sel   = sel_bit(SEL_SRA);
              legal = 1'b1;
            end
          end
          default: begin
            // sll, slt, sltu, xor, or, and: only the base funct7 exists.
            if (funct7 == F7_BASE) begin
              sel   = base_sel(funct3);
              legal = 1'b1;
            end
          end
        endcase
      end

      OPC_OPIMM: begin
        imm_sel = 1'b1;
        case (funct3)
          F3_SLL: begin
            shamt_sel = 1'b1;
            if (funct7 == F7_BASE) begin
              sel   = sel_bit(SEL_SLL);
              legal = 1'b1;
            end
          end
          F3_SRL: begin
            shamt_sel = 1'b1;
            if (funct7 == F7_BASE) begin
              sel   = sel_bit(SEL_SRL);
              legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              sel   = sel_bit(SEL_SRA);
              legal = 1'b1;
            end
          end
          default: begin
            // Upper bits are immediate here, so funct7 is not checked and
            // funct3 000 is always addi.
            sel   = base_sel(funct3);
            legal = 1'b1;
          end
        endcase
      end

      default: begin
        sel   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign illegal = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// One-entry pipeline register in front of the ALU result mux. Accepts an
// OP / OP-IMM instruction with its register operands over valid/ready,
// decodes it into one-hot ALU enables and presents the registered entry
// one cycle later. Illegal encodings still occupy the stage but raise
// `illegal` with all enables and rd_we low. Legal transfers are counted.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous kill of the held entry (top priority)
//   in_valid / in_ready   upstream handshake
//   instr, rs1_data, rs2_data   instruction and register read data
//   out_valid / out_ready downstream handshake
//   add_en .. and_en      registered one-hot ALU selects
//   op1_data, op2_data    ALU operands
//   rd_addr, rd_we        destination register and writeback enable
//   illegal               held entry is undecodable
//   issue_cnt             count of legal operations handed downstream
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             add_en,
  output logic             sub_en,
  output logic             sll_en,
  output logic             slt_en,
  output logic             sltu_en,
  output logic             xor_en,
  output logic             srl_en,
  output logic             sra_en,
  output logic             or_en,
  output logic             and_en,
  output logic [31:0]      op1_data,
  output logic [31:0]      op2_data,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  alu_sel_t dec_sel;
  logic     dec_illegal;
  logic     dec_imm_sel;
  logic     dec_shamt_sel;

  alu_op_decoder u_decoder (
    .instr     (instr),
    .sel       (dec_sel),
    .illegal   (dec_illegal),
    .imm_sel   (dec_imm_sel),
    .shamt_sel (dec_shamt_sel)
  );

  // ---------------------------------------------------------------------------
  // Operand 2 mux: shift amount, sign-extended immediate or rs2.
  // ---------------------------------------------------------------------------
  logic [31:0] op2_mux;

  always_comb begin
    if (dec_shamt_sel) begin
      op2_mux = {27'b0, instr[24:20]};
    end else if (dec_imm_sel) begin
      op2_mux = {{20{instr[31]}}, instr[31:20]};
    end else begin
      op2_mux = rs2_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic valid_q, valid_d;
  logic accept;
  logic xfer;

  // rst is folded in so the stage never advertises readiness while held in
  // reset; the register state alone would already read ready.
  assign in_ready = !rst && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Pipeline register and counter next-state
  // ---------------------------------------------------------------------------
  issue_entry_t    entry_q, entry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;

    // A flush kills the outgoing transfer as well, so it is never counted.
    if (xfer && !entry_q.illegal && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      valid_d         = 1'b0;
      entry_d.sel     = '0;
      entry_d.illegal = 1'b0;
      entry_d.rd_we   = 1'b0;
    end else if (accept) begin
      valid_d         = 1'b1;
      entry_d.sel     = dec_sel;
      entry_d.illegal = dec_illegal;
      entry_d.rd_we   = !dec_illegal && (instr[11:7] != 5'd0);
      entry_d.op1     = rs1_data;
      entry_d.op2     = op2_mux;
      entry_d.rd_addr = instr[11:7];
    end else if (xfer) begin
      // Emptying the stage: drop the control bits so the mux sees no select
      // while idle. Operand data is left as-is; it is ignored when invalid.
      valid_d         = 1'b0;
      entry_d.sel     = '0;
      entry_d.illegal = 1'b0;
      entry_d.rd_we   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; operand data is reset too because it is observable
  // on the outputs straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = valid_q;
  assign add_en    = entry_q.sel[SEL_ADD];
  assign sub_en    = entry_q.sel[SEL_SUB];
  assign sll_en    = entry_q.sel[SEL_SLL];
  assign slt_en    = entry_q.sel[SEL_SLT];
  assign sltu_en   = entry_q.sel[SEL_SLTU];
  assign xor_en    = entry_q.sel[SEL_XOR];
  assign srl_en    = entry_q.sel[SEL_SRL];
  assign sra_en    = entry_q.sel[SEL_SRA];
  assign or_en     = entry_q.sel[SEL_OR];
  assign and_en    = entry_q.sel[SEL_AND];
  assign op1_data  = entry_q.op1;
  assign op2_data  = entry_q.op2;
  assign rd_addr   = entry_q.rd_addr;
  assign rd_we     = entry_q.rd_we;
  assign illegal   = entry_q.illegal;
  assign issue_cnt = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipeline register stage directly upstream of the ALU result multiplexer. It accepts RV32I OP and OP-IMM instructions with operand data over a valid/ready handshake and decodes them into the ten one-hot ALU enables (`add_en` through `and_en`). It registers the enables together with the two ALU operands and the destination information, then presents them to the ALU and mux one cycle later. It also flags illegal encodings and counts issued operations.

## Interface
Parameters:
- `CNT_W`, 16, width of the issued-operation counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous kill of the held entry
- `in_valid`  in  1  instruction and operands valid
- `in_ready`  out  1  stage can accept this cycle
- `instr`  in  32  RV32I instruction word
- `rs1_data`  in  32  register-file read data, source 1
- `rs2_data`  in  32  register-file read data, source 2
- `out_valid`  out  1  registered entry valid
- `out_ready`  in  1  downstream consumes the entry
- `add_en`, `sub_en`, `sll_en`, `slt_en`, `sltu_en`, `xor_en`, `srl_en`, `sra_en`, `or_en`, `and_en`  out  1 each  registered one-hot ALU selects
- `op1_data`  out  32  ALU operand 1
- `op2_data`  out  32  ALU operand 2
- `rd_addr`  out  5  destination register, from `instr[11:7]`
- `rd_we`  out  1  writeback enable
- `illegal`  out  1  held entry is an undecodable instruction
- `issue_cnt`  out  CNT_W  count of legal operations handed downstream

## Operation
- Handshake:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - Accept when `in_valid && in_ready`.
  - Downstream transfer when `out_valid && out_ready`.
- Decode for OP (`instr[6:0]=0110011`), using funct3 = `instr[14:12]` and funct7 = `instr[31:25]`:
  - funct3 000: funct7 0000000 gives add; 0100000 gives sub.
  - 001: sll (funct7 0000000).
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: funct7 0000000 gives srl; 0100000 gives sra.
  - 110: or.
  - 111: and.
  - funct3 010, 011, 100, 110 and 111 require funct7 = 0000000.
  - Operands: `op2_data = rs2_data`.
- Decode for OP-IMM (`0010011`), using the same funct3 map with these differences:
  - funct3 000 is always add; there is no subtract.
  - 001 requires `instr[31:25]=0000000`.
  - 101 uses `instr[31:25]` to select srl or sra, as for OP.
  - `op2_data`: for funct3 001 and 101 it is `{27'b0, instr[24:20]}`; otherwise it is `instr[31:20]` sign-extended to 32 bits.
- `op1_data` is always `rs1_data`.
- Illegal encodings are any other opcode and any funct7 not listed above. For these:
  - All enables are 0.
  - `illegal=1`.
  - `rd_we=0`.
  - The entry still occupies the stage and transfers normally.
- Writeback: `rd_we = legal && (rd_addr != 0)`.
- Enables are exactly one-hot for a legal entry and all zero otherwise, including when `out_valid=0`. Consequently the mux outputs 0 when idle.
- `issue_cnt` increments by 1 on each downstream transfer with `illegal=0`. It wraps from `2^CNT_W-1` to 0.

## Timing
- Latency: one cycle from accept to `out_valid=1` with decoded fields.
- Throughput: one operation per cycle while `out_ready=1`.
- Stall: while `out_valid && !out_ready`, all outputs hold stable and `in_ready=0`.
- Simultaneous transfer and accept: the entry is replaced the next cycle and `out_valid` stays 1.
- Flush:
  - It has priority over everything.
  - Next cycle `out_valid=0`, the enables, `illegal` and `rd_we` are 0, and no input is accepted in the flush cycle.
  - `issue_cnt` does not increment even if `out_ready` was high.
- Reset, including assertion mid-operation:
  - `out_valid`, all enables, `illegal`, `rd_we` and `issue_cnt` clear to 0 immediately.
  - `op1_data`, `op2_data` and `rd_addr` clear to 0.
  - `in_ready` reads 0 while `rst` is high and 1 on the first cycle after deassertion.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OPC_OP` and `OPC_OPIMM`;
  - funct3 constants;
  - funct7 constants `F7_BASE` and `F7_ALT`;
  - a 10-bit `alu_sel_t` one-hot typedef with bit indices in port order.
- Sub-module `alu_op_decoder` is purely combinational:
  - input `instr`;
  - outputs `alu_sel_t`, `illegal`, and `imm_sel`/`shamt_sel`.
- The top module holds the handshake, the pipeline register, the operand mux and the counter.

## Test plan
- Reset, then OP add: `instr=0x003100B3` (add x1,x2,x3), `rs1=5`, `rs2=7` → next cycle `out_valid=1`, `add_en=1` only, `op1=5`, `op2=7`, `rd_addr=1`, `rd_we=1`. After transfer, `issue_cnt=1`.
- OP-IMM negative immediate: `instr=0xFFF10093` (addi x1,x2,-1) → `add_en=1`, `op2_data=0xFFFFFFFF`. Also `srai x5,x6,31` (`0x41F35293`) → `sra_en=1`, `op2_data=0x1F`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0` and outputs stable for all 3 cycles. Then `out_ready=1` → back-to-back sub, xor, and issue with one op per cycle, and `issue_cnt` increments by 3.
- Illegal: `instr=0x02208033` (funct7 0000001) → `illegal=1`, all enables 0, `rd_we=0`; `issue_cnt` unchanged after transfer. Also `rd=x0` legal add → `rd_we=0` with `add_en=1`.
- Flush and reset: flush while a stalled entry is held and `in_valid=1` → next cycle `out_valid=0` and the input is not accepted. Assert `rst` mid-stream → all outputs 0 immediately. Set `issue_cnt` near wrap with `CNT_W=4` and issue 17 ops → count reads 1.
